qubit_gate_sequencer: RTL



---
 rtl/qubit_ctrl_pkg.sv | 30 +++
 rtl/qgs_fifo.sv | 53 +++++
 rtl/qubit_gate_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/qubit_ctrl_pkg.sv
// Shared types for the qubit control slice: gate opcodes, sequencer states
// and the queued gate command record.
package qubit_ctrl_pkg;

  localparam int unsigned REP_W = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_X    = 2'b01,
    OP_H    = 2'b10,
    OP_WAIT = 2'b11
  } gate_op_e;

  typedef enum logic [1:0] {
    QGS_IDLE,
    QGS_ISSUE,
    QGS_GAP
  } qgs_state_e;

  typedef struct packed {
    gate_op_e         op;
    logic [REP_W-1:0] rep;
  } gate_cmd_t;

  // A repeat count of zero still costs one issue slot.
  function automatic logic [REP_W-1:0] rep_eff(input logic [REP_W-1:0] rep);
    return (rep == '0) ? REP_W'(1) : rep;
  endfunction

endpackage

// File: rtl/qgs_fifo.sv
// Command FIFO for the gate sequencer: power-of-two depth, level output
// one bit wider than the pointers so full and empty stay distinct.
module qgs_fifo
  import qubit_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type item_t = gate_cmd_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  item_t                    push_data,
  input  logic                     pop,
  output item_t                    pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  item_t             mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage write; the caller only pushes when there is room.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/qubit_gate_sequencer.sv
// Gate sequencer: queues {op, rep} commands and replays them as one-cycle
// X / Hadamard pulses, each issue slot followed by GAP idle cycles.
// Optional statistics counters are built when QGS_STATS_EN is defined.
module qubit_gate_sequencer
  import qubit_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [3:0]             cmd_rep,
  output logic                   apply_X_gate,
  output logic                   apply_Hadamard_gate,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef QGS_STATS_EN
  ,
  output logic [CNT_W-1:0]       x_count,
  output logic [CNT_W-1:0]       h_count
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  qgs_state_e        state;
  qgs_state_e        state_next;
  gate_op_e          cur_op;
  logic [REP_W-1:0]  remaining;
  logic [GAP_W-1:0]  gap_cnt;
  logic              push;
  logic              pop;
  logic              pulse_x;
  logic              pulse_h;
  gate_cmd_t         push_cmd;
  gate_cmd_t         head_cmd;

  assign cmd_ready = (fifo_level != LVL_W'(DEPTH)) && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == QGS_IDLE) && (fifo_level != '0) && !flush;
  assign push_cmd  = '{op: gate_op_e'(cmd_op), rep: cmd_rep};

  qgs_fifo #(
    .DEPTH  (DEPTH),
    .item_t (gate_cmd_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head_cmd),
    .level     (fifo_level)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= QGS_IDLE;
    else       state <= state_next;
  end

  // Next-state and raw pulse decode.
  always_comb begin
    state_next = state;
    pulse_x    = 1'b0;
    pulse_h    = 1'b0;
    case (state)
      QGS_IDLE: begin
        if (pop) state_next = QGS_ISSUE;
      end
      QGS_ISSUE: begin
        pulse_x = (cur_op == OP_X);
        pulse_h = (cur_op == OP_H);
        // remaining has not been decremented yet, so 1 means last slot.
        if (GAP > 0)                state_next = QGS_GAP;
        else if (remaining != 4'd1) state_next = QGS_ISSUE;
        else                        state_next = QGS_IDLE;
      end
      QGS_GAP: begin
        if (gap_cnt == GAP_W'(GAP - 1))
          state_next = (remaining != '0) ? QGS_ISSUE : QGS_IDLE;
      end
      default: state_next = QGS_IDLE;
    endcase
    if (flush) state_next = QGS_IDLE;
  end

  // Current command, repeat counter and gap counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_op    <= OP_NOP;
      remaining <= '0;
      gap_cnt   <= '0;
    end else if (flush) begin
      remaining <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        QGS_IDLE: begin
          if (pop) begin
            cur_op    <= head_cmd.op;
            remaining <= rep_eff(head_cmd.rep);
          end
        end
        QGS_ISSUE: begin
          remaining <= remaining - 1'b1;
          gap_cnt   <= '0;
        end
        QGS_GAP:  gap_cnt <= gap_cnt + 1'b1;
        default:  gap_cnt <= '0;
      endcase
    end
  end

  assign apply_X_gate        = pulse_x && !flush;
  assign apply_Hadamard_gate = pulse_h && !flush;
  assign busy                = (state != QGS_IDLE) || (fifo_level != '0);

`ifdef QGS_STATS_EN
  // Saturating pulse counters; cleared by reset only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_count <= '0;
      h_count <= '0;
    end else begin
      if (apply_X_gate && (x_count != '1))        x_count <= x_count + 1'b1;
      if (apply_Hadamard_gate && (h_count != '1)) h_count <= h_count + 1'b1;
    end
  end
`endif

endmodule
